// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline segment registers: state encoding, per-stage
// payload widths and the all-zero bubble constant.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } seg_state_e;

  localparam int IF_ID_DATA_W  = 64;
  localparam int IF_ID_CTRL_W  = 1;
  localparam int ID_EX_DATA_W  = 133;
  localparam int ID_EX_CTRL_W  = 14;
  localparam int EX_MEM_DATA_W = 101;
  localparam int EX_MEM_CTRL_W = 9;
  localparam int MEM_WB_DATA_W = 69;
  localparam int MEM_WB_CTRL_W = 3;

  // Widest payload any instance may carry; slots slice their own width from it.
  localparam int BUBBLE_MAX_W = 256;
  localparam logic [BUBBLE_MAX_W-1:0] BUBBLE = '0;

  function automatic logic [1:0] state_occupancy(input seg_state_e s);
    logic [1:0] occ;
    case (s)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_seg_slot.sv
// One valid+data+ctrl register. Clear wins over load and always leaves an
// all-zero payload so an empty slot reads as a NOP.
module pipe_seg_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = EX_MEM_DATA_W,
  parameter int CTRL_W = EX_MEM_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic [CTRL_W-1:0] ctrl_r;

  // Slot register: reset/clear to bubble, otherwise load whole payload or hold.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      valid_r <= 1'b0;
      data_r  <= BUBBLE[DATA_W-1:0];
      ctrl_r  <= BUBBLE[CTRL_W-1:0];
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
      ctrl_r  <= load_ctrl;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
      ctrl_r  <= ctrl_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;
  assign ctrl  = ctrl_r;

endmodule

// File: rtl/pipe_seg_reg.sv
// Pipeline segment register with valid/ready handshake and flush-to-bubble.
// Define PIPE_SEG_REG_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_seg_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = EX_MEM_DATA_W,
  parameter int CTRL_W = EX_MEM_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  seg_state_e        state_r;
  seg_state_e        state_next_s;
  logic [1:0]        occupancy_r;
  logic              accept_s;
  logic              release_s;
  logic              main_load_s;
  logic              main_clear_s;
  logic              main_valid_s;
  logic [DATA_W-1:0] main_data_s;
  logic [CTRL_W-1:0] main_ctrl_s;
  logic [DATA_W-1:0] main_load_data_s;
  logic [CTRL_W-1:0] main_load_ctrl_s;

  assign accept_s  = in_valid && in_ready;
  assign release_s = main_valid_s && out_ready;

`ifdef PIPE_SEG_REG_SKID_EN
  logic              in_ready_r;
  logic              skid_load_s;
  logic              skid_clear_s;
  logic              main_src_skid_s;
  logic              skid_valid_s;
  logic [DATA_W-1:0] skid_data_s;
  logic [CTRL_W-1:0] skid_ctrl_s;

  // State register plus status outputs computed from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      occupancy_r <= 2'd0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      occupancy_r <= state_occupancy(state_next_s);
      in_ready_r  <= (state_next_s != TWO);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: state_next_s = accept_s ? ONE : EMPTY;
        ONE: begin
          if (accept_s && !release_s) begin
            state_next_s = TWO;
          end else if (!accept_s && release_s) begin
            state_next_s = EMPTY;
          end else begin
            state_next_s = ONE;
          end
        end
        TWO:     state_next_s = release_s ? ONE : TWO;
        default: state_next_s = EMPTY;
      endcase
    end
  end

  // Slot control; the skid entry always moves into main when main drains in TWO.
  always_comb begin
    main_load_s     = 1'b0;
    main_clear_s    = 1'b0;
    main_src_skid_s = 1'b0;
    skid_load_s     = 1'b0;
    skid_clear_s    = 1'b0;
    if (flush) begin
      main_clear_s = 1'b1;
      skid_clear_s = 1'b1;
    end else begin
      case (state_r)
        EMPTY: main_load_s = accept_s;
        ONE: begin
          if (accept_s && release_s) begin
            main_load_s = 1'b1;
          end else if (accept_s) begin
            skid_load_s = 1'b1;
          end else if (release_s) begin
            main_clear_s = 1'b1;
          end else begin
            main_load_s = 1'b0;
          end
        end
        TWO: begin
          if (release_s) begin
            main_load_s     = 1'b1;
            main_src_skid_s = 1'b1;
            skid_clear_s    = 1'b1;
          end else begin
            main_load_s = 1'b0;
          end
        end
        default: begin
          main_clear_s = 1'b1;
          skid_clear_s = 1'b1;
        end
      endcase
    end
  end

  assign main_load_data_s = main_src_skid_s ? skid_data_s : in_data;
  assign main_load_ctrl_s = main_src_skid_s ? skid_ctrl_s : in_ctrl;
  assign in_ready         = in_ready_r;

  pipe_seg_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load_s),
    .clear     (skid_clear_s),
    .load_data (in_data),
    .load_ctrl (in_ctrl),
    .valid     (skid_valid_s),
    .data      (skid_data_s),
    .ctrl      (skid_ctrl_s)
  );

  // Skid valid mirrors state TWO; kept only for observability.
  logic skid_valid_unused_s;
  assign skid_valid_unused_s = skid_valid_s;
`else
  // State register plus occupancy computed from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_next_s;
      occupancy_r <= state_occupancy(state_next_s);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY:   state_next_s = accept_s ? ONE : EMPTY;
        ONE:     state_next_s = (release_s && !accept_s) ? EMPTY : ONE;
        default: state_next_s = EMPTY;
      endcase
    end
  end

  // Slot control; in ONE an accept only happens alongside a release.
  always_comb begin
    main_load_s  = 1'b0;
    main_clear_s = 1'b0;
    if (flush) begin
      main_clear_s = 1'b1;
    end else begin
      case (state_r)
        EMPTY: main_load_s = accept_s;
        ONE: begin
          if (accept_s) begin
            main_load_s = 1'b1;
          end else if (release_s) begin
            main_clear_s = 1'b1;
          end else begin
            main_load_s = 1'b0;
          end
        end
        default: main_clear_s = 1'b1;
      endcase
    end
  end

  assign main_load_data_s = in_data;
  assign main_load_ctrl_s = in_ctrl;
  assign in_ready         = out_ready || !main_valid_s;
`endif

  pipe_seg_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (main_load_s),
    .clear     (main_clear_s),
    .load_data (main_load_data_s),
    .load_ctrl (main_load_ctrl_s),
    .valid     (main_valid_s),
    .data      (main_data_s),
    .ctrl      (main_ctrl_s)
  );

  assign out_valid = main_valid_s;
  assign out_data  = main_data_s;
  assign out_ctrl  = main_ctrl_s;
  assign occupancy = occupancy_r;

endmodule

// File: tb/tb_pipe_seg_reg.sv
// Scoreboard bench for pipe_seg_reg; expectations follow PIPE_SEG_REG_SKID_EN.
module tb_pipe_seg_reg;

  localparam int DW = 101;
  localparam int CW = 9;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } item_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  item_t sb[$];
  item_t mon_item;
  int    tests = 0;
  int    fails = 0;
  bit    mon_en = 1'b0;

  always #5 clk = ~clk;

  pipe_seg_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c, input bit exp_accept);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
    if (exp_accept) sb.push_back('{d: d, c: c});
  endtask

  // Monitor: every release pops the scoreboard; bubbles must read all-zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got data %0h with nothing expected", out_data);
        end else begin
          mon_item = sb.pop_front();
          chk("out_data", 128'(out_data), 128'(mon_item.d));
          chk("out_ctrl", 128'(out_ctrl), 128'(mon_item.c));
        end
      end else if (!out_valid) begin
        chk("bubble_data", 128'(out_data), 128'd0);
        chk("bubble_ctrl", 128'(out_ctrl), 128'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, DW'(32'hDEADBEEF), 9'h1FF, 1'b0);
    cyc(); cyc();
    smp();
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data",  128'(out_data),  128'd0);
    chk("rst_out_ctrl",  128'(out_ctrl),  128'd0);
    chk("rst_occupancy", 128'(occupancy), 128'd0);
    cyc();
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    mon_en = 1'b1;
    smp();
    chk("rst_in_ready", 128'(in_ready), 128'd1);

    // Streaming: each value appears exactly one cycle after it is driven.
    for (int i = 1; i <= 8; i++) begin
      cyc();
      drive(1'b1, DW'(i), CW'(i), 1'b1);
      if (i >= 2) begin
        smp();
        chk("stream_occ", 128'(occupancy), 128'd1);
        chk("stream_lag", 128'(out_data), 128'(i - 1));
      end
    end
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    smp();
    chk("stream_last", 128'(out_data), 128'd8);
    cyc(); smp();
    chk("stream_drain_occ", 128'(occupancy), 128'd0);

`ifdef PIPE_SEG_REG_SKID_EN
    cyc(); out_ready = 1'b0;
    drive(1'b1, DW'(32'hA), 9'h00A, 1'b1);
    cyc();
    drive(1'b1, DW'(32'hB), 9'h00B, 1'b1);
    smp();
    chk("skid_ready_one", 128'(in_ready), 128'd1);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    smp();
    chk("skid_occ2", 128'(occupancy), 128'd2);
    chk("skid_ready_full", 128'(in_ready), 128'd0);
    chk("skid_head_a", 128'(out_data), 128'hA);
    cyc(); out_ready = 1'b1;
    smp();
    chk("skid_ready_rel", 128'(in_ready), 128'd0);
    cyc(); smp();
    chk("skid_ready_after", 128'(in_ready), 128'd1);
    chk("skid_head_b", 128'(out_data), 128'hB);
    chk("skid_occ1", 128'(occupancy), 128'd1);
    cyc(); smp();
    chk("skid_drain_occ", 128'(occupancy), 128'd0);

    cyc(); out_ready = 1'b0;
    drive(1'b1, DW'(32'hD), 9'h00D, 1'b1);
    cyc();
    drive(1'b1, DW'(32'hE), 9'h00E, 1'b1);
    cyc();
    drive(1'b1, DW'(32'hC), 9'h00C, 1'b0);
    flush = 1'b1;
    smp();
    chk("flush_pre_occ", 128'(occupancy), 128'd2);
`else
    cyc(); out_ready = 1'b0;
    drive(1'b1, DW'(32'hA), 9'h00A, 1'b1);
    cyc();
    drive(1'b1, DW'(32'hB), 9'h00B, 1'b0);
    smp();
    chk("ns_ready_stall", 128'(in_ready), 128'd0);
    chk("ns_occ1", 128'(occupancy), 128'd1);
    cyc(); out_ready = 1'b1;
    drive(1'b1, DW'(32'hB), 9'h00B, 1'b1);
    smp();
    chk("ns_ready_comb", 128'(in_ready), 128'd1);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    smp();
    chk("ns_b2b_b", 128'(out_data), 128'hB);
    chk("ns_b2b_occ", 128'(occupancy), 128'd1);
    cyc(); smp();
    chk("ns_drain_occ", 128'(occupancy), 128'd0);

    cyc(); out_ready = 1'b0;
    drive(1'b1, DW'(32'hD), 9'h00D, 1'b1);
    cyc();
    drive(1'b1, DW'(32'hC), 9'h00C, 1'b0);
    flush = 1'b1;
    smp();
    chk("flush_pre_occ", 128'(occupancy), 128'd1);
`endif
    // Flushed entries are never released, so drop them from the scoreboard.
    sb.delete();
    cyc();
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    smp();
    chk("flush_out_valid", 128'(out_valid), 128'd0);
    chk("flush_out_ctrl",  128'(out_ctrl),  128'd0);
    chk("flush_occ",       128'(occupancy), 128'd0);
    chk("flush_in_ready",  128'(in_ready),  128'd1);

    // Bubble: control driven with in_valid low must never leak through.
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive(1'b0, '1, 9'h1FF, 1'b0);
      smp();
      chk("bubble_valid", 128'(out_valid), 128'd0);
      chk("bubble_ctrl_hold", 128'(out_ctrl), 128'd0);
    end

    cyc();
    drive(1'b1, DW'(32'hF00D), 9'h155, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    smp();
    chk("post_flush_valid", 128'(out_valid), 128'd1);
    cyc(); cyc();
    smp();
    chk("sb_drained", 128'(sb.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
